// File: rtl/normalize_iter_if.sv
// Handshake bundle for normalize_iter: input vector channel and result channel.
// master: upstream producer / downstream consumer side; slave: the normalizer.
interface normalize_iter_if #(
    parameter int DATA_W = 8
) ();
    localparam int SHW = $clog2(DATA_W) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [SHW-1:0]    out_shamt;
    logic              out_zero;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_shamt, out_zero
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_shamt, out_zero
    );
endinterface

// File: rtl/normalize_iter.sv
// Multi-cycle leading-zero normalizer: shifts the accepted vector left until its
// MSB is set, examining up to STEP bits per cycle. Reports the shift applied and
// an all-zero flag. Result registers are held stable while DONE is backpressured.
// Optional build macro NORMALIZE_ZERO_BYPASS_EN: an all-zero input skips the
// SHIFT iterations and enters DONE on the acceptance edge itself.
module normalize_iter #(
    parameter int DATA_W = 8,
    parameter int STEP   = 1
) (
    input logic             clk,
    input logic             rst,
    normalize_iter_if.slave bus
);
    localparam int SHW = $clog2(DATA_W) + 1;
    localparam int WIN = (STEP < DATA_W) ? STEP : DATA_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] work_q, work_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [SHW-1:0]    res_shamt_q, res_shamt_d;
    logic              res_zero_q, res_zero_d;

    logic [SHW-1:0]    z;
    logic              found;
    logic [SHW:0]      cnt_sum;

    // Leading zeros within the top WIN bits of the working vector (WIN if none set)
    always_comb begin
        z     = SHW'(WIN);
        found = 1'b0;
        for (int unsigned i = 0; i < WIN; i++) begin
            if (!found && work_q[DATA_W-1-i]) begin
                z     = SHW'(i);
                found = 1'b1;
            end
        end
    end

    // One extra bit so the running count cannot wrap before the zero test
    assign cnt_sum = {1'b0, cnt_q} + {1'b0, z};

    // Next-state, datapath updates and handshake outputs
    always_comb begin
        state_d       = state_q;
        work_d        = work_q;
        cnt_d         = cnt_q;
        res_data_d    = res_data_q;
        res_shamt_d   = res_shamt_q;
        res_zero_d    = res_zero_q;
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
`ifdef NORMALIZE_ZERO_BYPASS_EN
                    if (bus.in_data == '0) begin
                        res_data_d  = '0;
                        res_shamt_d = '0;
                        res_zero_d  = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        work_d  = bus.in_data;
                        cnt_d   = '0;
                        state_d = S_SHIFT;
                    end
`else
                    work_d  = bus.in_data;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
`endif
                end
            end

            S_SHIFT: begin
                work_d = work_q << z;
                cnt_d  = cnt_sum[SHW-1:0];
                if (z < SHW'(WIN)) begin
                    // A set bit lies inside the window: this shift finishes the job
                    res_data_d  = work_q << z;
                    res_shamt_d = cnt_sum[SHW-1:0];
                    res_zero_d  = 1'b0;
                    state_d     = S_DONE;
                end else if (cnt_sum >= (SHW+1)'(DATA_W)) begin
                    // Every original bit has been scanned without finding a one
                    res_data_d  = '0;
                    res_shamt_d = '0;
                    res_zero_d  = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_DONE;
                end
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any work in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            res_data_q  <= '0;
            res_shamt_q <= '0;
            res_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_shamt_q <= res_shamt_d;
            res_zero_q  <= res_zero_d;
        end
    end

    assign bus.out_data  = res_data_q;
    assign bus.out_shamt = res_shamt_q;
    assign bus.out_zero  = res_zero_q;

endmodule
